// File: rtl/obj_fetch_pkg.sv
// Shared types and constants for the object pixel fetcher and its 8-entry pixel FIFO.
// Used by obj_fetch_fifo and obj_lane_merge.
package obj_fetch_pkg;

    localparam int unsigned OBJ_FIFO_DEPTH = 8;
    localparam logic [3:0]  OBJ_SLOT_EMPTY = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StOam0,
        StOam1,
        StLoReq,
        StLoDat,
        StHiReq,
        StHiDat,
        StMerge
    } fetch_state_e;

    typedef struct packed {
        logic [1:0] color;
        logic [2:0] pal;
        logic       prio;
        logic [3:0] slot;
    } obj_entry_t;

    localparam obj_entry_t OBJ_ENTRY_EMPTY = '{
        color: 2'd0,
        pal:   3'd0,
        prio:  1'b0,
        slot:  OBJ_SLOT_EMPTY
    };

    // Lane 0 is the FIFO head, i.e. the leftmost pixel unless X-flipped.
    function automatic logic [1:0] obj_pixel(input logic [7:0] lo, input logic [7:0] hi,
                                             input logic [2:0] lane, input logic flip);
        logic [2:0] bit_sel;
        bit_sel = flip ? lane : (3'd7 - lane);
        return {hi[bit_sel], lo[bit_sel]};
    endfunction

endpackage

// File: rtl/obj_lane_merge.sv
// Combinational merge of one freshly fetched object pixel into one FIFO lane.
// Transparent new pixels never overwrite; otherwise DMG or CGB priority decides.
module obj_lane_merge
    import obj_fetch_pkg::*;
(
    input  obj_entry_t cur,
    input  obj_entry_t new_pix,
    input  logic       cgb_rule,
    output obj_entry_t nxt
);

    logic cur_empty;
    logic new_wins_slot;

    assign cur_empty     = (cur.color == 2'd0);
    assign new_wins_slot = cgb_rule && (new_pix.slot < cur.slot);

    always_comb begin
        nxt = cur;
        if ((new_pix.color != 2'd0) && (cur_empty || new_wins_slot)) begin
            nxt = new_pix;
        end
    end

endmodule

// File: rtl/obj_fetch_fifo.sv
// Object tile-row fetcher feeding an 8-entry object pixel FIFO for the BG/OBJ mixer.
// Define OBJ_FETCH_CGB_PRIO_EN to enable CGB slot-index priority and VRAM bank select.
module obj_fetch_fifo
    import obj_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        isGBC,
    input  logic        lcd_on,
    input  logic        line_reset,
    input  logic        sprite_fetch,
    input  logic [10:0] sprite_addr,
    input  logic [7:0]  sprite_attr,
    input  logic [3:0]  sprite_index,
    output logic        sprite_fetch_done,
    output logic        vram_rd,
    output logic [11:0] vram_addr,
    output logic        vram_bank,
    input  logic [7:0]  vram_data,
    input  logic        shift,
    output logic [1:0]  obj_pix_color,
    output logic [2:0]  obj_pix_pal,
    output logic        obj_pix_prio
);

    fetch_state_e state_q, state_d;

    logic        clear;
    logic        rd_q, rd_d;
    logic        done_q, done_d;
    logic [11:0] addr_q, addr_d;
    logic        bank_q, bank_d;
    logic        bank_sel;
    logic        cgb_rule;
    logic [7:0]  attr_q, attr_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  lo_q, hi_q;
    logic [2:0]  new_pal;

    obj_entry_t fifo_q   [OBJ_FIFO_DEPTH];
    obj_entry_t fifo_d   [OBJ_FIFO_DEPTH];
    obj_entry_t shifted  [OBJ_FIFO_DEPTH];
    obj_entry_t merged   [OBJ_FIFO_DEPTH];
    obj_entry_t new_pix  [OBJ_FIFO_DEPTH];

    // Line start or LCD off aborts any fetch in progress and blanks the FIFO.
    assign clear = line_reset | ~lcd_on;

`ifdef OBJ_FETCH_CGB_PRIO_EN
    assign cgb_rule = isGBC;
    assign bank_sel = isGBC & attr_d[3];
`else
    assign cgb_rule = 1'b0;
    assign bank_sel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = sprite_fetch ? StOam0 : StIdle;
                StOam0:  state_d = StOam1;
                StOam1:  state_d = StLoReq;
                StLoReq: state_d = StLoDat;
                StLoDat: state_d = StHiReq;
                StHiReq: state_d = StHiDat;
                StHiDat: state_d = StMerge;
                StMerge: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic: the VRAM/done outputs are registered against the upcoming state.
    always_comb begin
        rd_d   = (state_d == StLoReq) || (state_d == StHiReq);
        done_d = (state_d == StMerge);
        attr_d = (state_q == StOam1) ? sprite_attr : attr_q;
        idx_d  = (state_q == StOam1) ? sprite_index : idx_q;
        addr_d = addr_q;
        bank_d = bank_q;
        if (state_d == StLoReq) begin
            addr_d = {sprite_addr, 1'b0};
            bank_d = bank_sel;
        end else if (state_d == StHiReq) begin
            addr_d = {sprite_addr, 1'b1};
            bank_d = bank_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            bank_q <= 1'b0;
            attr_q <= '0;
            idx_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else if (ce) begin
            rd_q   <= rd_d;
            done_q <= done_d;
            addr_q <= addr_d;
            bank_q <= bank_d;
            attr_q <= attr_d;
            idx_q  <= idx_d;
            if (state_q == StLoDat) begin
                lo_q <= vram_data;
            end
            if (state_q == StHiDat) begin
                hi_q <= vram_data;
            end
        end
    end

    assign new_pal = isGBC ? attr_q[2:0] : {2'b00, attr_q[4]};

    // Shift happens before the merge, so a same-cycle pop merges onto the shifted lanes.
    always_comb begin
        for (int i = 0; i < OBJ_FIFO_DEPTH - 1; i++) begin
            shifted[i] = shift ? fifo_q[i + 1] : fifo_q[i];
        end
        shifted[OBJ_FIFO_DEPTH - 1] = shift ? OBJ_ENTRY_EMPTY : fifo_q[OBJ_FIFO_DEPTH - 1];
    end

    for (genvar g = 0; g < OBJ_FIFO_DEPTH; g++) begin : g_lane
        assign new_pix[g] = '{
            color: obj_pixel(lo_q, hi_q, 3'(g), attr_q[5]),
            pal:   new_pal,
            prio:  attr_q[7],
            slot:  idx_q
        };

        obj_lane_merge u_lane_merge (
            .cur      (shifted[g]),
            .new_pix  (new_pix[g]),
            .cgb_rule (cgb_rule),
            .nxt      (merged[g])
        );
    end

    always_comb begin
        for (int i = 0; i < OBJ_FIFO_DEPTH; i++) begin
            if (clear) begin
                fifo_d[i] = OBJ_ENTRY_EMPTY;
            end else if (state_q == StMerge) begin
                fifo_d[i] = merged[i];
            end else begin
                fifo_d[i] = shifted[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OBJ_FIFO_DEPTH; i++) begin
                fifo_q[i] <= OBJ_ENTRY_EMPTY;
            end
        end else if (ce) begin
            for (int i = 0; i < OBJ_FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign sprite_fetch_done = done_q;
    assign vram_rd           = rd_q;
    assign vram_addr         = addr_q;
    assign vram_bank         = bank_q;
    assign obj_pix_color     = fifo_q[0].color;
    assign obj_pix_pal       = fifo_q[0].pal;
    assign obj_pix_prio      = fifo_q[0].prio;

endmodule

// File: tb/tb_obj_fetch_fifo.sv
// Directed bench for obj_fetch_fifo: fetch timing, flip, DMG/CGB merge, shift and aborts.
// Expected CGB results follow OBJ_FETCH_CGB_PRIO_EN when the bench is built with it.
module tb_obj_fetch_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        isGBC;
    logic        lcd_on;
    logic        line_reset;
    logic        sprite_fetch;
    logic [10:0] sprite_addr;
    logic [7:0]  sprite_attr;
    logic [3:0]  sprite_index;
    logic        sprite_fetch_done;
    logic        vram_rd;
    logic [11:0] vram_addr;
    logic        vram_bank;
    logic [7:0]  vram_data;
    logic        shift;
    logic [1:0]  obj_pix_color;
    logic [2:0]  obj_pix_pal;
    logic        obj_pix_prio;

    logic [7:0]  vram_lo;
    logic [7:0]  vram_hi;
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_col  [8];
    int          exp_pal  [8];
    int          exp_prio [8];
    logic        cgb_bank;

    obj_fetch_fifo dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ce                (ce),
        .isGBC             (isGBC),
        .lcd_on            (lcd_on),
        .line_reset        (line_reset),
        .sprite_fetch      (sprite_fetch),
        .sprite_addr       (sprite_addr),
        .sprite_attr       (sprite_attr),
        .sprite_index      (sprite_index),
        .sprite_fetch_done (sprite_fetch_done),
        .vram_rd           (vram_rd),
        .vram_addr         (vram_addr),
        .vram_bank         (vram_bank),
        .vram_data         (vram_data),
        .shift             (shift),
        .obj_pix_color     (obj_pix_color),
        .obj_pix_pal       (obj_pix_pal),
        .obj_pix_prio      (obj_pix_prio)
    );

    always #5 clk = ~clk;

    // VRAM: data for the requested plane appears on the ce after the read strobe.
    always @(posedge clk) begin
        if (ce && vram_rd) begin
            vram_data <= vram_addr[0] ? vram_hi : vram_lo;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request, lets it be sampled, then drops it (the fetch must not abort).
    task automatic start_fetch(input logic [10:0] a, input logic [7:0] attr, input logic [3:0] idx,
                               input logic [7:0] lo, input logic [7:0] hi);
        vram_lo      = lo;
        vram_hi      = hi;
        sprite_addr  = a;
        sprite_attr  = attr;
        sprite_index = idx;
        sprite_fetch = 1'b1;
        tick();
        sprite_fetch = 1'b0;
    endtask

    task automatic run_fetch(input logic [10:0] a, input logic [7:0] attr, input logic [3:0] idx,
                             input logic [7:0] lo, input logic [7:0] hi, input logic bank);
        start_fetch(a, attr, idx, lo, hi);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("rd_n+%0d", k), 16'(vram_rd), 16'((k == 3) || (k == 5)));
            check($sformatf("done_n+%0d", k), 16'(sprite_fetch_done), 16'(k == 7));
            if (k == 3 || k == 5) begin
                check($sformatf("addr_n+%0d", k), 16'(vram_addr), 16'({a, k == 5}));
                check($sformatf("bank_n+%0d", k), 16'(vram_bank), 16'(bank));
            end
            if (k < 8) tick();
        end
    endtask

    // Reads all eight lanes at the head, shifting between reads; leaves the FIFO empty.
    task automatic dump(input string name);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_col%0d", name, i), 16'(obj_pix_color), 16'(exp_col[i]));
            check($sformatf("%s_pal%0d", name, i), 16'(obj_pix_pal), 16'(exp_pal[i]));
            check($sformatf("%s_prio%0d", name, i), 16'(obj_pix_prio), 16'(exp_prio[i]));
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        ce           = 1'b1;
        isGBC        = 1'b0;
        lcd_on       = 1'b1;
        line_reset   = 1'b0;
        sprite_fetch = 1'b0;
        sprite_addr  = '0;
        sprite_attr  = '0;
        sprite_index = '0;
        shift        = 1'b0;
        vram_lo      = '0;
        vram_hi      = '0;
        vram_data    = '0;
`ifdef OBJ_FETCH_CGB_PRIO_EN
        cgb_bank = 1'b1;
`else
        cgb_bank = 1'b0;
`endif

        tick();
        tick();
        check("rst_done", 16'(sprite_fetch_done), 16'h0);
        check("rst_rd", 16'(vram_rd), 16'h0);
        check("rst_addr", 16'(vram_addr), 16'h0);
        check("rst_bank", 16'(vram_bank), 16'h0);
        check("rst_col", 16'(obj_pix_color), 16'h0);
        check("rst_pal", 16'(obj_pix_pal), 16'h0);
        check("rst_prio", 16'(obj_pix_prio), 16'h0);
        reset_n = 1'b1;
        tick();

        // Plain fetch: lo F0, hi CC.
        run_fetch(11'h123, 8'h00, 4'd0, 8'hF0, 8'hCC, 1'b0);
        exp_col  = '{3, 3, 1, 1, 2, 2, 0, 0};
        exp_pal  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_prio = '{0, 0, 0, 0, 0, 0, 0, 0};
        dump("plain");

        // X-flip with BG priority and DMG palette 1.
        run_fetch(11'h2A5, 8'hB0, 4'd1, 8'hF0, 8'hCC, 1'b0);
        exp_col  = '{0, 0, 2, 2, 1, 1, 3, 3};
        exp_pal  = '{0, 0, 1, 1, 1, 1, 1, 1};
        exp_prio = '{0, 0, 1, 1, 1, 1, 1, 1};
        dump("flip");

        // DMG overlap: earlier-fetched slot 2 keeps every lane.
        run_fetch(11'h010, 8'h00, 4'd2, 8'hFF, 8'h00, 1'b0);
        run_fetch(11'h011, 8'h01, 4'd0, 8'h55, 8'h55, 1'b0);
        exp_col  = '{1, 1, 1, 1, 1, 1, 1, 1};
        exp_pal  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_prio = '{0, 0, 0, 0, 0, 0, 0, 0};
        dump("dmg_ovl");

        // CGB overlap: slot 0 (pal 3) over slot 2 (pal 5) only with slot priority enabled.
        isGBC = 1'b1;
        run_fetch(11'h020, 8'h0D, 4'd2, 8'hFF, 8'h00, cgb_bank);
        run_fetch(11'h021, 8'h0B, 4'd0, 8'h55, 8'h55, cgb_bank);
`ifdef OBJ_FETCH_CGB_PRIO_EN
        exp_col  = '{1, 3, 1, 3, 1, 3, 1, 3};
        exp_pal  = '{5, 3, 5, 3, 5, 3, 5, 3};
`else
        exp_col  = '{1, 1, 1, 1, 1, 1, 1, 1};
        exp_pal  = '{5, 5, 5, 5, 5, 5, 5, 5};
`endif
        exp_prio = '{0, 0, 0, 0, 0, 0, 0, 0};
        dump("cgb_ovl");
        isGBC = 1'b0;

        // Three pops after a fetch: head becomes old entry 3, tail refills transparent.
        run_fetch(11'h030, 8'h90, 4'd3, 8'hF0, 8'hCC, 1'b0);
        shift = 1'b1;
        tick();
        tick();
        tick();
        shift = 1'b0;
        exp_col  = '{1, 2, 2, 0, 0, 0, 0, 0};
        exp_pal  = '{1, 1, 1, 0, 0, 0, 0, 0};
        exp_prio = '{1, 1, 1, 0, 0, 0, 0, 0};
        dump("shift3");

        // Without ce nothing advances even with a request pending.
        ce = 1'b0;
        sprite_fetch = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("ce_rd", 16'(vram_rd), 16'h0);
        check("ce_done", 16'(sprite_fetch_done), 16'h0);
        sprite_fetch = 1'b0;
        ce = 1'b1;
        tick();
        check("ce_idle_rd", 16'(vram_rd), 16'h0);

        // line_reset during HI_REQ aborts the fetch and blanks a populated FIFO.
        run_fetch(11'h040, 8'h00, 4'd0, 8'hF0, 8'hCC, 1'b0);
        start_fetch(11'h041, 8'h00, 4'd1, 8'hFF, 8'hFF);
        for (int k = 1; k < 5; k++) tick();
        check("lr_hireq_rd", 16'(vram_rd), 16'h1);
        line_reset = 1'b1;
        tick();
        line_reset = 1'b0;
        check("lr_rd", 16'(vram_rd), 16'h0);
        check("lr_done", 16'(sprite_fetch_done), 16'h0);
        check("lr_col", 16'(obj_pix_color), 16'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("lr_done_after%0d", k), 16'(sprite_fetch_done), 16'h0);
        end
        exp_col  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_pal  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_prio = '{0, 0, 0, 0, 0, 0, 0, 0};
        dump("lr");

        // Asynchronous reset mid-fetch.
        run_fetch(11'h050, 8'h10, 4'd0, 8'hF0, 8'hCC, 1'b0);
        start_fetch(11'h051, 8'h00, 4'd1, 8'hFF, 8'hFF);
        tick();
        tick();
        check("ar_lo_req_rd", 16'(vram_rd), 16'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_rd", 16'(vram_rd), 16'h0);
        check("ar_addr", 16'(vram_addr), 16'h0);
        check("ar_col", 16'(obj_pix_color), 16'h0);
        check("ar_pal", 16'(obj_pix_pal), 16'h0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("ar_done_after%0d", k), 16'(sprite_fetch_done), 16'h0);
        end
        dump("ar");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/obj_fetch_fifo.md
# obj_fetch_fifo

Object pixel fetcher and 8-entry object pixel FIFO, sitting directly downstream of the OAM sprite evaluator. When the evaluator raises `sprite_fetch`, this block does three things:
- reads the two tile-row bytes from VRAM at the evaluator's `sprite_addr`;
- applies X-flip and merges the eight resulting pixels into the object FIFO using the DMG/CGB priority rules;
- pulses `sprite_fetch_done` so the evaluator retires that slot.

The FIFO head feeds the BG/OBJ pixel mixer, which pops it once per output pixel.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: asynchronous active-low reset
- `ce` in 1: pixel clock enable; all state advances only on `ce`
- `isGBC` in 1: CGB mode
- `lcd_on` in 1: LCD enable; low clears FSM and FIFO
- `line_reset` in 1: start of line (same pulse as the evaluator's `oam_eval_reset`); clears FSM and FIFO
- `sprite_fetch` in 1: fetch request from the evaluator
- `sprite_addr` in 11: tile-row address, Y-flip already applied
- `sprite_attr` in 8: OAM attribute byte
- `sprite_index` in 4: line slot 0–9 of the sprite being fetched
- `sprite_fetch_done` out 1: one-`ce` completion pulse
- `vram_rd` out 1: VRAM read strobe
- `vram_addr` out 12: `{sprite_addr, plane}`
- `vram_bank` out 1: VRAM bank select
- `vram_data` in 8: read data, valid on the `ce` after `vram_rd`
- `shift` in 1: mixer pops the FIFO head
- `obj_pix_color` out 2: head colour; 0 = transparent
- `obj_pix_pal` out 3: head palette, CGB `attr[2:0]`, DMG `{2'b00, attr[4]}`
- `obj_pix_prio` out 1: head BG-over-OBJ flag (`attr[7]`)

## Operation
FSM states: IDLE → OAM0 → OAM1 → LO_REQ → LO_DAT → HI_REQ → HI_DAT → MERGE → IDLE. Each transition takes one `ce`.

Per state:
- **IDLE:** leaves only when `sprite_fetch` = 1.
- **OAM0, OAM1:** wait states covering the evaluator's two-cycle tile/attr OAM read. `sprite_attr` and `sprite_index` are latched at the end of OAM1.
- **LO_REQ:** `vram_rd` = 1, `vram_addr` = `{sprite_addr, 1'b0}`.
- **LO_DAT:** captures the low plane.
- **HI_REQ:** `vram_rd` = 1, `vram_addr` = `{sprite_addr, 1'b1}`.
- **HI_DAT:** captures the high plane.
- **MERGE:** writes the FIFO; `sprite_fetch_done` is registered high for exactly this one `ce` period.

Pixel formation:
- Pixel i (i = 0 at the FIFO head) = `{hi[7-i], lo[7-i]}`.
- With `attr[5]` set (X-flip), pixel i = `{hi[i], lo[i]}` instead.

FIFO entry fields: colour[1:0], pal[2:0], prio, slot[3:0].

Merge rule per lane (new pixel vs existing entry):
- New colour 0: the lane is never written.
- DMG rule: write only if the existing colour is 0, so the earlier-fetched (lower X) object wins.
- CGB rule (macro-gated, see Configuration): write if the existing colour is 0, or if new slot < existing slot.

Shift behaviour:
- `shift` moves all entries toward the head.
- Entry 7 refills with colour 0, pal 0, prio 0, slot 15.
- Outputs reflect entry 0 combinationally.

Simultaneous events:
- `shift` and MERGE in the same `ce`: shift first, then merge onto the shifted contents.
- `line_reset` or `lcd_on` = 0 (checked each `ce`) takes priority over everything: FSM returns to IDLE, the FIFO is cleared to transparent, `sprite_fetch_done` = 0.
- `sprite_fetch` dropping mid-fetch does not abort the fetch: the sequence completes and still pulses done.
- `sprite_fetch` still high in IDLE right after done (another sprite at the same X) starts a new fetch.

## Timing
- Reset values:
  - `sprite_fetch_done` = 0, `vram_rd` = 0, `vram_addr` = 0, `vram_bank` = 0
  - FSM = IDLE
  - all FIFO entries = transparent, slot 15, so `obj_pix_color`/`obj_pix_pal`/`obj_pix_prio` = 0
- Fetch latency:
  - `sprite_fetch` sampled high on `ce` n → `vram_rd` during `ce` n+3 and n+5
  - FIFO updated and `sprite_fetch_done` high during `ce` n+7
  - back in IDLE at n+8
- Throughput: one object per 8 `ce`.
- `vram_data` is sampled in LO_DAT and HI_DAT only.
- `vram_addr` and `vram_bank` hold their last value outside the REQ states.
- The mixer is expected to stall `shift` while the FSM is busy. Shifting during a fetch is legal but does not change the merge alignment rule above.

## Configuration
- Macro `OBJ_FETCH_CGB_PRIO_EN` defined:
  - in CGB mode (`isGBC` = 1), merge uses the CGB slot-index rule;
  - `vram_bank` = `isGBC & attr[3]`.
- Macro not defined:
  - the DMG rule applies in both modes;
  - `vram_bank` is tied to 0;
  - the slot field is still stored but unused.

## Structure
- Package `obj_fetch_pkg` holds:
  - FSM state enum;
  - FIFO entry struct (colour, pal, prio, slot);
  - constants `OBJ_FIFO_DEPTH` = 8, `OBJ_SLOT_EMPTY` = 4'hF.
- Sub-module `obj_lane_merge`: purely combinational per-lane merge (existing entry, new entry, `cgb_rule`) → next entry, instantiated 8×.
- FSM, plane capture, flip and shift logic live in the top module.

## Test plan
- Single fetch, `attr` = 8'h00, `lo` = 8'hF0, `hi` = 8'hCC → `vram_addr` = `{A,0}` then `{A,1}`, done at n+7; FIFO colours head-first 3,3,1,1,2,2,0,0.
- Same data with `attr[5]` = 1 → head-first 0,0,2,2,1,1,3,3.
- DMG overlap: slot 2 colours all 1, then slot 0 colours {0,3,0,3,0,3,0,3} → slot 2 kept everywhere.
- CGB with macro, same stimulus → odd lanes take colour 3, pal from slot 0.
- `shift` pulsed 3× after a fetch → head is former entry 3; entries 5–7 transparent, slot 15.
- `line_reset` asserted during HI_REQ → FSM IDLE next `ce`, no done pulse, FIFO all transparent; `reset_n` low mid-fetch gives the same result asynchronously.
